mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the core's single memory port between instruction fetch and the load/store stage. It sits between the pipeline and the AXI bridge. Each requester uses the same valid/ready/resp convention as the fetch port, and so does the downstream port. One transaction is outstanding at a time. Loads/stores win ties. A starvation counter bounds how long fetch can be locked out.

## Interface
- MAX_WAIT, 4, consecutive tie-losses fetch tolerates before it is forced to win (1..15)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- if_valid  in  1  fetch request; held until if_ready
- if_addr  in  64  fetch address
- if_size  in  2  fetch size code
- if_ready  out  1  fetch completion pulse
- if_data_read  out  64  fetch read data, valid when if_ready=1
- if_resp  out  2  fetch response, valid when if_ready=1
- mem_valid  in  1  load/store request; held until mem_ready
- mem_we  in  1  1=store, 0=load
- mem_addr  in  64  load/store address
- mem_size  in  2  size code
- mem_wdata  in  64  store data
- mem_wstrb  in  8  store byte strobes
- mem_ready  out  1  load/store completion pulse
- mem_data_read  out  64  load data, valid when mem_ready=1
- mem_resp  out  2  response, valid when mem_ready=1
- out_valid  out  1  downstream request, registered
- out_we, out_addr, out_size, out_wdata, out_wstrb  out  1/64/2/64/8  latched request fields, registered
- out_ready  in  1  downstream completion pulse
- out_data_read  in  64  downstream read data
- out_resp  in  2  downstream response
- busy  out  1  1 when state != IDLE

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE, neither valid: stay.
- IDLE, only if_valid: latch fetch fields with out_we=0, out_wdata=0, out_wstrb=0; go BUSY_IF.
- IDLE, only mem_valid: latch mem fields; go BUSY_MEM.
- IDLE, both valid:
  - starve_cnt == MAX_WAIT: fetch wins; starve_cnt <= 0.
  - otherwise: mem wins; starve_cnt <= starve_cnt + 1, saturating at MAX_WAIT.
- Any fetch grant clears starve_cnt. A mem grant with if_valid=0 leaves starve_cnt unchanged.
- BUSY_x: out_valid=1, all out_* fields held constant.
  - On out_ready=1, pulse x_ready combinationally (x_ready = out_ready & state==BUSY_x) and go IDLE.
  - out_valid is 0 in IDLE.
- out_data_read and out_resp pass combinationally to both if_* and mem_* return buses. Requesters qualify them with their own ready.
- A nonzero out_resp still completes the transaction normally. The response code is passed through; the arbiter takes no error action.
- Requester dropping valid while its request is BUSY does not abort it. The transaction completes and ready still pulses.
- A requester changing addr/size/data while BUSY has no effect; fields are latched at grant.
- out_ready while IDLE is ignored: no ready pulse, no state change.
- starve_cnt width: 4 bits.

## Timing
- Reset (reset=0 at an edge) sets:
  - state=IDLE, starve_cnt=0
  - out_valid=0, out_we=0, out_addr=0, out_size=0, out_wdata=0, out_wstrb=0
  - if_ready=0, mem_ready=0 (from the next cycle), busy=0
- Reset mid-transaction abandons it: no ready pulse is issued, and the downstream bridge is reset alongside.
- Latency:
  - request visible in IDLE at cycle t gives out_valid=1 at t+1
  - out_ready at cycle k gives x_ready at cycle k (zero added latency) and IDLE at k+1
  - next grant is decided at k+1; next out_valid at k+2
- Minimum period per transaction: 2 cycles + downstream latency.
- Requesters deassert valid or present a new request in the cycle after their ready. A still-asserted valid at k+1 is treated as a new request.

## Test plan
- Single fetch: if_valid=1, addr=0x8000_0000, size=2; bridge returns out_ready at t+3 with data 0x0000_0013_0000_0093, resp=0.
  - Expect out_valid t+1..t+3, out_we=0.
  - Expect if_ready=1 only at t+3 with that data; mem_ready stays 0.
- Store: mem_we=1, addr=0x8000_1008, wdata=0xDEAD_BEEF, wstrb=0x0F.
  - Expect out_* to carry exactly these fields.
  - Expect mem_ready on out_ready; busy falls the cycle after.
- Tie, MAX_WAIT=4: both valid continuously, mem re-requests after each ready.
  - Expect grant order mem,mem,mem,mem,fetch,mem...
  - starve_cnt goes 1,2,3,4,0.
- Requester drops mem_valid one cycle after grant: the transaction still completes, mem_ready pulses once, and fetch is not served in its place.
- reset=0 during BUSY_IF:
  - next cycle out_valid=0, busy=0, starve_cnt=0.
  - A late out_ready after reset yields no if_ready.
- out_ready pulse in IDLE with no requests: no ready outputs and the state stays IDLE. A nonzero out_resp (2'b10) during BUSY_IF is returned on if_resp with if_ready=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter between instruction fetch and load/store for the single memory port.
// One transaction outstanding; loads/stores win ties, fetch is forced through after MAX_WAIT losses.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [63:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_ready,
    output logic [63:0] if_data_read,
    output logic [1:0]  if_resp,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [63:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [63:0] mem_data_read,
    output logic [1:0]  mem_resp,
    output logic        out_valid,
    output logic        out_we,
    output logic [63:0] out_addr,
    output logic [1:0]  out_size,
    output logic [63:0] out_wdata,
    output logic [7:0]  out_wstrb,
    input  logic        out_ready,
    input  logic [63:0] out_data_read,
    input  logic [1:0]  out_resp,
    output logic        busy,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_starve_cnt
);

    // Handshake: a requester holds valid until its ready pulse; ready is a one-cycle
    // completion strobe (out_ready & matching BUSY state) that qualifies data/resp.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    logic [3:0]  r_starve_cnt;
    logic        r_out_valid;
    logic        r_out_we;
    logic [63:0] r_out_addr;
    logic [1:0]  r_out_size;
    logic [63:0] r_out_wdata;
    logic [7:0]  r_out_wstrb;

    state_t      w_state_nxt;
    logic [3:0]  w_starve_nxt;
    logic        w_out_valid_nxt;
    logic        w_out_we_nxt;
    logic [63:0] w_out_addr_nxt;
    logic [1:0]  w_out_size_nxt;
    logic [63:0] w_out_wdata_nxt;
    logic [7:0]  w_out_wstrb_nxt;
    logic        w_grant_if;
    logic        w_grant_mem;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_out_valid  <= 1'b0;
            r_out_we     <= 1'b0;
            r_out_addr   <= 64'd0;
            r_out_size   <= 2'd0;
            r_out_wdata  <= 64'd0;
            r_out_wstrb  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_we     <= w_out_we_nxt;
            r_out_addr   <= w_out_addr_nxt;
            r_out_size   <= w_out_size_nxt;
            r_out_wdata  <= w_out_wdata_nxt;
            r_out_wstrb  <= w_out_wstrb_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_we_nxt    = r_out_we;
        w_out_addr_nxt  = r_out_addr;
        w_out_size_nxt  = r_out_size;
        w_out_wdata_nxt = r_out_wdata;
        w_out_wstrb_nxt = r_out_wstrb;
        w_grant_if      = 1'b0;
        w_grant_mem     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_if  = if_valid & (~mem_valid | (r_starve_cnt == LP_MAX_WAIT));
                w_grant_mem = mem_valid & ~w_grant_if;
                if (w_grant_if) begin
                    w_state_nxt     = ST_BUSY_IF;
                    w_starve_nxt    = 4'd0;
                    w_out_valid_nxt = 1'b1;
                    w_out_we_nxt    = 1'b0;
                    w_out_addr_nxt  = if_addr;
                    w_out_size_nxt  = if_size;
                    w_out_wdata_nxt = 64'd0;
                    w_out_wstrb_nxt = 8'd0;
                end else if (w_grant_mem) begin
                    w_state_nxt     = ST_BUSY_MEM;
                    w_out_valid_nxt = 1'b1;
                    w_out_we_nxt    = mem_we;
                    w_out_addr_nxt  = mem_addr;
                    w_out_size_nxt  = mem_size;
                    w_out_wdata_nxt = mem_wdata;
                    w_out_wstrb_nxt = mem_wstrb;
                    // Only a lost tie counts against fetch.
                    if (if_valid && (r_starve_cnt != LP_MAX_WAIT)) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                end
            end
            ST_BUSY_IF, ST_BUSY_MEM: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign if_ready       = out_ready & (r_state == ST_BUSY_IF);
    assign mem_ready      = out_ready & (r_state == ST_BUSY_MEM);
    assign if_data_read   = out_data_read;
    assign if_resp        = out_resp;
    assign mem_data_read  = out_data_read;
    assign mem_resp       = out_resp;
    assign out_valid      = r_out_valid;
    assign out_we         = r_out_we;
    assign out_addr       = r_out_addr;
    assign out_size       = r_out_size;
    assign out_wdata      = r_out_wdata;
    assign out_wstrb      = r_out_wstrb;
    assign busy           = (r_state != ST_IDLE);
    assign dbg_state      = r_state;
    assign dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions queued at issue,
// checked by an independent monitor whenever a ready pulse appears.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic [1:0]  if_resp;
  logic        mem_valid;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic [63:0] mem_data_read;
  logic [1:0]  mem_resp;
  logic        out_valid;
  logic        out_we;
  logic [63:0] out_addr;
  logic [1:0]  out_size;
  logic [63:0] out_wdata;
  logic [7:0]  out_wstrb;
  logic        out_ready;
  logic [63:0] out_data_read;
  logic [1:0]  out_resp;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  int total = 0;
  int bad = 0;

  // {port (1=mem), resp, data}
  logic [66:0] exp_q[$];

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_data_read(mem_data_read), .mem_resp(mem_resp),
    .out_valid(out_valid), .out_we(out_we), .out_addr(out_addr),
    .out_size(out_size), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_ready(out_ready), .out_data_read(out_data_read), .out_resp(out_resp),
    .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  task automatic bridge_reply(input int delay, input logic [63:0] data, input logic [1:0] resp);
    for (int i = 0; i < delay; i++) tick();
    out_ready     = 1'b1;
    out_data_read = data;
    out_resp      = resp;
    tick();
    out_ready     = 1'b0;
    out_data_read = 64'd0;
    out_resp      = 2'd0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [66:0] act;
    logic [66:0] req;
    if (if_ready || mem_ready) begin
      act = mem_ready ? {1'b1, mem_resp, mem_data_read} : {1'b0, if_resp, if_data_read};
      total++;
      if (if_ready && mem_ready) begin
        bad++;
        $display("FAIL both_ready: act=11 req=one-hot");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: act=0x%0h req=none", act);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          bad++;
          $display("FAIL completion: act=0x%0h req=0x%0h", act, req);
        end
      end
    end
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IF   = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;

  logic [1:0] tie_state [6] = '{S_MEM, S_MEM, S_MEM, S_MEM, S_IF, S_MEM};
  logic [3:0] tie_cnt   [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

  initial begin
    reset = 1'b0;
    if_valid = 1'b0; if_addr = 64'd0; if_size = 2'd0;
    mem_valid = 1'b0; mem_we = 1'b0; mem_addr = 64'd0; mem_size = 2'd0;
    mem_wdata = 64'd0; mem_wstrb = 8'd0;
    out_ready = 1'b0; out_data_read = 64'd0; out_resp = 2'd0;
    tick(); tick(); tick();

    // reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_out_wstrb", 64'(out_wstrb), 64'd0);
    check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    reset = 1'b1;
    tick();

    // single fetch
    if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'd2;
    exp_q.push_back({1'b0, 2'b00, 64'h0000_0013_0000_0093});
    tick();
    check("f_out_valid", 64'(out_valid), 64'd1);
    check("f_out_we", 64'(out_we), 64'd0);
    check("f_out_addr", out_addr, 64'h8000_0000);
    check("f_out_size", 64'(out_size), 64'd2);
    check("f_out_wstrb", 64'(out_wstrb), 64'd0);
    tick();
    check("f_out_valid_hold", 64'(out_valid), 64'd1);
    tick();
    out_ready = 1'b1; out_data_read = 64'h0000_0013_0000_0093; out_resp = 2'd0;
    #1;
    check("f_if_ready", 64'(if_ready), 64'd1);
    check("f_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    out_ready = 1'b0; out_data_read = 64'd0; if_valid = 1'b0;
    check("f_busy_after", 64'(busy), 64'd0);

    // store
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_1008; mem_size = 2'd3;
    mem_wdata = 64'hDEAD_BEEF; mem_wstrb = 8'h0F;
    exp_q.push_back({1'b1, 2'b00, 64'h0});
    tick();
    check("s_out_we", 64'(out_we), 64'd1);
    check("s_out_addr", out_addr, 64'h8000_1008);
    check("s_out_wdata", out_wdata, 64'hDEAD_BEEF);
    check("s_out_wstrb", 64'(out_wstrb), 64'h0F);
    check("s_busy", 64'(busy), 64'd1);
    bridge_reply(1, 64'h0, 2'd0);
    mem_valid = 1'b0; mem_we = 1'b0;
    check("s_busy_after", 64'(busy), 64'd0);

    // tie: both valid continuously
    if_valid = 1'b1; if_addr = 64'h8000_0100; mem_valid = 1'b1; mem_addr = 64'h8000_2000;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({(tie_state[i] == S_MEM), 2'b00, 64'(i + 100)});
      tick();
      check("tie_grant", 64'(dbg_state), 64'(tie_state[i]));
      check("tie_starve", 64'(dbg_starve_cnt), 64'(tie_cnt[i]));
      bridge_reply(1, 64'(i + 100), 2'd0);
    end
    if_valid = 1'b0; mem_valid = 1'b0;

    // mem drops valid after grant; fields changed while busy
    mem_valid = 1'b1; mem_addr = 64'h8000_3000;
    exp_q.push_back({1'b1, 2'b01, 64'h1234});
    tick();
    check("drop_grant", 64'(dbg_state), 64'(S_MEM));
    check("drop_starve", 64'(dbg_starve_cnt), 64'd1);
    mem_valid = 1'b0; mem_addr = 64'h0BAD_0BAD;
    tick();
    check("drop_addr_held", out_addr, 64'h8000_3000);
    check("drop_out_valid", 64'(out_valid), 64'd1);
    bridge_reply(0, 64'h1234, 2'b01);
    check("drop_idle", 64'(busy), 64'd0);
    tick();
    check("drop_no_regrant", 64'(busy), 64'd0);

    // reset during BUSY_IF
    if_valid = 1'b1; if_addr = 64'h8000_4000;
    tick();
    check("rb_grant", 64'(dbg_state), 64'(S_IF));
    reset = 1'b0; if_valid = 1'b0;
    tick();
    reset = 1'b1;
    check("rb_out_valid", 64'(out_valid), 64'd0);
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_starve", 64'(dbg_starve_cnt), 64'd0);
    out_ready = 1'b1; out_data_read = 64'hFFFF;
    #1;
    check("rb_late_if_ready", 64'(if_ready), 64'd0);
    tick();
    out_ready = 1'b0; out_data_read = 64'd0;

    // out_ready in IDLE
    out_ready = 1'b1; out_resp = 2'b10;
    #1;
    check("idle_if_ready", 64'(if_ready), 64'd0);
    check("idle_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    out_ready = 1'b0; out_resp = 2'd0;
    check("idle_state", 64'(dbg_state), 64'(S_IDLE));

    // error response on fetch passes through
    if_valid = 1'b1; if_addr = 64'h8000_5000;
    exp_q.push_back({1'b0, 2'b10, 64'hABCD});
    tick();
    tick();
    out_ready = 1'b1; out_data_read = 64'hABCD; out_resp = 2'b10;
    #1;
    check("err_if_ready", 64'(if_ready), 64'd1);
    check("err_if_resp", 64'(if_resp), 64'd2);
    tick();
    out_ready = 1'b0; out_resp = 2'd0; if_valid = 1'b0;
    check("err_idle", 64'(busy), 64'd0);

    tick(); tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
